// File: rtl/mig_native_responder.sv
// Stand-in for a MIG UI native-interface core: queues commands and write data, executes them
// in order against an internal RAM and returns read data after a fixed pipeline delay.
module mig_native_responder #(
    parameter int unsigned MIG_Data_Port_Size = 128,
    parameter int unsigned MIG_Addr_Port_Size = 28,
    parameter int unsigned Mem_Depth          = 256,
    parameter int unsigned Calib_Delay        = 16,
    parameter int unsigned Rd_Latency         = 4,
    parameter int unsigned Cmd_Fifo_Depth     = 4,
    parameter int unsigned Wdf_Fifo_Depth     = 4,
    parameter int unsigned Stall_Period       = 0
) (
    input  logic                          aclk,
    input  logic                          areset,
    output logic                          init_calib,
    input  logic [MIG_Addr_Port_Size-1:0] app_addr,
    input  logic [2:0]                    app_cmd,
    input  logic                          app_en,
    output logic                          app_rdy,
    input  logic [MIG_Data_Port_Size-1:0] app_wdf_data,
    input  logic                          app_wdf_wren,
    input  logic                          app_wdf_end,
    output logic                          app_wdf_rdy,
    output logic [MIG_Data_Port_Size-1:0] app_rd_data,
    output logic                          app_rd_data_valid,
    output logic                          app_rd_data_end,
    output logic                          protocol_err
);

    localparam int unsigned IdxW   = $clog2(Mem_Depth);
    localparam int unsigned CmdAw  = (Cmd_Fifo_Depth > 1) ? $clog2(Cmd_Fifo_Depth) : 1;
    localparam int unsigned WdfAw  = (Wdf_Fifo_Depth > 1) ? $clog2(Wdf_Fifo_Depth) : 1;
    localparam int unsigned CalW   = $clog2(Calib_Delay + 1);
    localparam int unsigned StallW = (Stall_Period > 1) ? $clog2(Stall_Period) : 1;

    typedef enum logic {StCalib, StRun} state_e;

    state_e                  state;
    logic [CalW-1:0]         calib_cnt;
    logic [StallW-1:0]       stall_cnt;
    logic                    run;
    logic                    stall;

    logic [2:0]              cq_cmd [2**CmdAw];
    logic [IdxW-1:0]         cq_idx [2**CmdAw];
    logic [CmdAw-1:0]        cq_wp, cq_rp;
    logic [CmdAw:0]          cq_cnt;
    logic [MIG_Data_Port_Size-1:0] wq_data [2**WdfAw];
    logic [WdfAw-1:0]        wq_wp, wq_rp;
    logic [WdfAw:0]          wq_cnt;
    logic [MIG_Data_Port_Size-1:0] ram [Mem_Depth];

    logic                    cmd_push, cmd_pop, wdf_push, wdf_pop;
    logic                    head_valid, exec_wr, exec_rd;
    logic [2:0]              head_cmd;
    logic [IdxW-1:0]         head_idx, addr_idx;
    logic                    err_d;
    logic [Rd_Latency:0]     pv;
    logic [MIG_Data_Port_Size-1:0] pd [Rd_Latency+1];
    logic                    unused_addr;

    assign addr_idx    = app_addr[IdxW+2:3];
    assign unused_addr = ^{app_addr[MIG_Addr_Port_Size-1:IdxW+3], app_addr[2:0]};

    assign run   = (state == StRun);
    assign stall = (Stall_Period != 0) && (stall_cnt == StallW'(Stall_Period - 1));

    assign app_rdy     = run && (cq_cnt != (CmdAw+1)'(Cmd_Fifo_Depth)) && !stall;
    assign app_wdf_rdy = run && (wq_cnt != (WdfAw+1)'(Wdf_Fifo_Depth));

    assign cmd_push   = app_en && app_rdy;
    assign wdf_push   = app_wdf_wren && app_wdf_rdy;
    assign head_valid = (cq_cnt != '0);
    assign head_cmd   = cq_cmd[cq_rp];
    assign head_idx   = cq_idx[cq_rp];
    // A write at the head blocks everything behind it until its data shows up.
    assign exec_wr    = head_valid && (head_cmd == 3'd0) && (wq_cnt != '0);
    assign exec_rd    = head_valid && (head_cmd == 3'd1);
    assign cmd_pop    = head_valid && ((head_cmd != 3'd0) || (wq_cnt != '0));
    assign wdf_pop    = exec_wr;

    assign err_d = (cmd_push && (app_cmd > 3'd1)) || (app_wdf_wren != app_wdf_end) ||
                   (!run && (app_en || app_wdf_wren));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= StCalib;
            calib_cnt  <= '0;
            init_calib <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            case (state)
                StCalib: begin
                    if (calib_cnt == CalW'(Calib_Delay - 1)) begin
                        state      <= StRun;
                        init_calib <= 1'b1;
                    end else begin
                        calib_cnt <= calib_cnt + CalW'(1);
                    end
                end
                default: begin
                    if (Stall_Period != 0) stall_cnt <= stall ? '0 : stall_cnt + StallW'(1);
                end
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cq_wp  <= '0;
            cq_rp  <= '0;
            cq_cnt <= '0;
            wq_wp  <= '0;
            wq_rp  <= '0;
            wq_cnt <= '0;
        end else begin
            if (cmd_push) cq_wp <= cq_wp + CmdAw'(1);
            if (cmd_pop)  cq_rp <= cq_rp + CmdAw'(1);
            if (cmd_push && !cmd_pop) cq_cnt <= cq_cnt + (CmdAw+1)'(1);
            if (!cmd_push && cmd_pop) cq_cnt <= cq_cnt - (CmdAw+1)'(1);
            if (wdf_push) wq_wp <= wq_wp + WdfAw'(1);
            if (wdf_pop)  wq_rp <= wq_rp + WdfAw'(1);
            if (wdf_push && !wdf_pop) wq_cnt <= wq_cnt + (WdfAw+1)'(1);
            if (!wdf_push && wdf_pop) wq_cnt <= wq_cnt - (WdfAw+1)'(1);
        end
    end

    // Queue storage and RAM carry no reset; the RAM keeps its contents across areset.
    always_ff @(posedge aclk) begin
        if (cmd_push) begin
            cq_cmd[cq_wp] <= app_cmd;
            cq_idx[cq_wp] <= addr_idx;
        end
        if (wdf_push) wq_data[wq_wp] <= app_wdf_data;
        if (exec_wr)  ram[head_idx] <= wq_data[wq_rp];
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pv <= '0;
            for (int unsigned i = 0; i <= Rd_Latency; i++) pd[i] <= '0;
        end else begin
            pv    <= {pv[Rd_Latency-1:0], exec_rd};
            pd[0] <= exec_rd ? ram[head_idx] : '0;
            for (int unsigned i = 1; i <= Rd_Latency; i++) pd[i] <= pd[i-1];
        end
    end

    assign app_rd_data       = pd[Rd_Latency];
    assign app_rd_data_valid = pv[Rd_Latency];
    assign app_rd_data_end   = pv[Rd_Latency];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) protocol_err <= 1'b0;
        else        protocol_err <= protocol_err || err_d;
    end

endmodule

// File: tb/tb_mig_native_responder.sv
// Bench for mig_native_responder: table vectors, hand sequences for the multi-cycle corners
// and a randomized run scored against an in-order queue/array model.
module tb_mig_native_responder;

    localparam int DW = 128, AW = 28, Depth = 256, CalD = 16, RdL = 4, Stall = 3;

    logic          aclk = 1'b0, areset = 1'b1;
    logic          init_calib, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end;
    logic          protocol_err;
    logic [AW-1:0] app_addr = '0;
    logic [2:0]    app_cmd = '0;
    logic          app_en = 1'b0, app_wdf_wren = 1'b0, app_wdf_end = 1'b0;
    logic [DW-1:0] app_wdf_data = '0, app_rd_data;

    mig_native_responder #(
        .MIG_Data_Port_Size(DW), .MIG_Addr_Port_Size(AW), .Mem_Depth(Depth),
        .Calib_Delay(CalD), .Rd_Latency(RdL), .Cmd_Fifo_Depth(4), .Wdf_Fifo_Depth(4),
        .Stall_Period(Stall)
    ) dut (
        .aclk(aclk), .areset(areset), .init_calib(init_calib), .app_addr(app_addr),
        .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .protocol_err(protocol_err)
    );

    always #5 aclk = ~aclk;

    int total = 0, bad = 0, cyc = 0, vcount = 0, run_k = 0, last_acc = 0, first_valid_cyc = 0;
    bit armed = 0, chk_stall = 0;

    always @(posedge aclk) cyc++;

    function automatic void check_int(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endfunction

    function automatic void check_dat(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Reference model: program-order queues, executed as far as the data on hand allows.
    typedef struct {logic [2:0] cmd; int idx; bit has_exp; logic [DW-1:0] exp;} mcmd_t;
    mcmd_t         m_cq[$];
    logic [DW-1:0] m_dq[$];
    logic [DW-1:0] m_mem [Depth];
    logic [DW-1:0] exp_q[$];

    function automatic void model_run();
        while (m_cq.size() != 0) begin
            if (m_cq[0].cmd == 3'd0) begin
                if (m_dq.size() == 0) break;
                m_mem[m_cq[0].idx] = m_dq.pop_front();
            end else if (m_cq[0].cmd == 3'd1) begin
                exp_q.push_back(m_cq[0].has_exp ? m_cq[0].exp : m_mem[m_cq[0].idx]);
            end
            void'(m_cq.pop_front());
        end
    endfunction

    function automatic logic [DW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(negedge aclk) begin
        if (app_rd_data_valid) begin
            vcount++;
            if (armed) begin
                first_valid_cyc = cyc;
                armed = 0;
            end
            check_int("rd_end", int'(app_rd_data_end), 1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: valid beat with data %0h, required none", app_rd_data);
            end else begin
                check_dat("rd_data", app_rd_data, exp_q.pop_front());
            end
        end
        if (!init_calib) run_k = 0;
        else begin
            if (chk_stall) check_int("stall_rdy", int'(app_rdy), int'((run_k % 3) != 2));
            run_k++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [AW-1:0] a, input bit has_exp,
                          input logic [DW-1:0] e);
        bit    ok = 0;
        mcmd_t m;
        app_cmd = c; app_addr = a; app_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (app_rdy) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            @(posedge aclk);
            #1;
            last_acc = cyc;
            m.cmd = c; m.idx = int'(a >> 3) % Depth; m.has_exp = has_exp; m.exp = e;
            m_cq.push_back(m);
            model_run();
        end else begin
            total++;
            bad++;
            $display("FAIL cmd_accept_timeout: app_rdy=%0b, required 1 within 200 cycles", app_rdy);
        end
        app_en = 1'b0;
    endtask

    task automatic do_wdf(input logic [DW-1:0] d);
        bit ok = 0;
        app_wdf_data = d; app_wdf_wren = 1'b1; app_wdf_end = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (app_wdf_rdy) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            @(posedge aclk);
            #1;
            m_dq.push_back(d);
            model_run();
        end else begin
            total++;
            bad++;
            $display("FAIL wdf_accept_timeout: app_wdf_rdy=%0b, required 1 within 200 cycles",
                     app_wdf_rdy);
        end
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    task automatic check_outputs_zero(string tag);
        check_int({tag, "_init_calib"}, int'(init_calib), 0);
        check_int({tag, "_app_rdy"}, int'(app_rdy), 0);
        check_int({tag, "_app_wdf_rdy"}, int'(app_wdf_rdy), 0);
        check_int({tag, "_rd_valid"}, int'(app_rd_data_valid), 0);
        check_int({tag, "_rd_end"}, int'(app_rd_data_end), 0);
        check_int({tag, "_perr"}, int'(protocol_err), 0);
        check_dat({tag, "_rd_data"}, app_rd_data, '0);
    endtask

    // Asserts reset, checks outputs drop at once, then counts the recalibration time.
    task automatic do_reset();
        int n;
        areset = 1'b1;
        #1;
        check_outputs_zero("reset");
        m_cq.delete(); m_dq.delete(); exp_q.delete();
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        for (n = 0; n < CalD + 6; n++) begin
            @(negedge aclk);
            if (init_calib) break;
        end
        check_int("calib_cycles", n, CalD);
        idle(1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge aclk);
            if (exp_q.size() == 0 && m_cq.size() == 0) break;
        end
        check_int("drain_pending", exp_q.size() + m_cq.size(), 0);
        idle(1);
    endtask

    typedef struct {bit rd; logic [AW-1:0] addr; logic [DW-1:0] data;} vec_t;
    vec_t vt[$];

    initial begin
        int            acc0, v0;
        bit            first_rd;
        logic [AW-1:0] a, a2;
        logic [DW-1:0] d;

        for (int i = 0; i < 8; i++) vt.push_back('{1'b0, AW'(i * 8), DW'(8'hA0 + i)});
        for (int i = 0; i < 8; i++) vt.push_back('{1'b1, AW'(i * 8), DW'(8'hA0 + i)});
        vt.push_back('{1'b0, AW'(0), DW'(8'h55)});
        vt.push_back('{1'b0, AW'(2048), DW'(8'h66)});
        vt.push_back('{1'b1, AW'(0), DW'(8'h66)});
        vt.push_back('{1'b0, AW'(28'h0FF_FFF8), DW'(8'h77)});
        vt.push_back('{1'b1, AW'(28'h000_07F8), DW'(8'h77)});
        vt.push_back('{1'b1, AW'(8), DW'(8'hA1)});

        // Reset values, then calibration with an illegal app_en pulse at cycle 5.
        repeat (2) @(posedge aclk);
        #1;
        check_outputs_zero("por");
        areset = 1'b0;
        for (int n = 0; n <= CalD; n++) begin
            @(negedge aclk);
            check_int("calib_init", int'(init_calib), int'(n == CalD));
            check_int("calib_rdy", int'(app_rdy), int'(n == CalD));
            check_int("calib_wdf_rdy", int'(app_wdf_rdy), int'(n == CalD));
            if (n == 4) begin
                check_int("perr_pre_pulse", int'(protocol_err), 0);
                app_en = 1'b1;
            end
            if (n == 5) begin
                app_en = 1'b0;
                check_int("perr_calib_pulse", int'(protocol_err), 1);
            end
        end
        idle(1);
        do_reset();

        // Table-driven write/readback, including address wrap.
        first_rd = 1;
        acc0 = 0;
        foreach (vt[i]) begin
            if (!vt[i].rd) begin
                do_wdf(vt[i].data);
                do_cmd(3'd0, vt[i].addr, 1'b0, '0);
            end else if (first_rd) begin
                idle(6);
                armed = 1;
                do_cmd(3'd1, vt[i].addr, 1'b1, vt[i].data);
                acc0 = last_acc;
                first_rd = 0;
            end else begin
                do_cmd(3'd1, vt[i].addr, 1'b1, vt[i].data);
            end
        end
        drain();
        check_int("rd_latency", first_valid_cyc - acc0, RdL + 1);

        // Data ahead of commands fills the write-data queue.
        for (int i = 0; i < 4; i++) do_wdf(DW'(8'hD0 + i));
        @(negedge aclk);
        check_int("wdf_full", int'(app_wdf_rdy), 0);
        idle(1);
        for (int i = 0; i < 4; i++) do_cmd(3'd0, AW'((20 + i) * 8), 1'b0, '0);
        for (int i = 0; i < 4; i++) do_cmd(3'd1, AW'((20 + i) * 8), 1'b0, '0);
        drain();

        // Write without data blocks the read behind it.
        do_cmd(3'd0, AW'(30 * 8), 1'b0, '0);
        do_cmd(3'd1, AW'(30 * 8), 1'b0, '0);
        v0 = vcount;
        idle(12);
        check_int("read_blocked", vcount - v0, 0);
        do_wdf(DW'(16'hBEEF));
        drain();

        // Command queue full while the head write waits for data.
        for (int i = 0; i < 4; i++) do_cmd(3'd0, AW'((40 + i) * 8), 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check_int("cmd_full", int'(app_rdy), 0);
        end
        idle(1);
        for (int i = 0; i < 4; i++) do_wdf(DW'(12'hC00 + i));
        for (int i = 0; i < 4; i++) do_cmd(3'd1, AW'((40 + i) * 8), 1'b0, '0);
        drain();

        // Continuous reads under periodic stalls.
        chk_stall = 1;
        v0 = vcount;
        for (int i = 0; i < 30; i++) do_cmd(3'd1, AW'((i % 8) * 8), 1'b0, '0);
        chk_stall = 0;
        drain();
        check_int("stall_beats", vcount - v0, 30);

        // Randomized traffic against the model.
        for (int i = 8; i < 16; i++) begin
            do_wdf(rnd());
            do_cmd(3'd0, AW'(i * 8), 1'b0, '0);
        end
        for (int n = 0; n < 80; n++) begin
            a = AW'($urandom());
            a[10:3] = 8'($urandom_range(0, 15));
            a[2:0] = 3'b0;
            d = rnd();
            case ($urandom_range(0, 3))
                0: do_cmd(3'd1, a, 1'b0, '0);
                1: begin do_wdf(d); do_cmd(3'd0, a, 1'b0, '0); end
                2: begin do_cmd(3'd0, a, 1'b0, '0); do_wdf(d); end
                default: begin
                    a2 = AW'($urandom());
                    a2[10:3] = 8'($urandom_range(0, 15));
                    a2[2:0] = 3'b0;
                    do_cmd(3'd0, a, 1'b0, '0);
                    do_cmd(3'd1, a2, 1'b0, '0);
                    do_wdf(d);
                end
            endcase
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        // Illegal command is flagged and discarded.
        check_int("perr_before_illegal", int'(protocol_err), 0);
        do_cmd(3'd3, AW'(8), 1'b0, '0);
        do_cmd(3'd1, AW'(8), 1'b0, '0);
        drain();
        check_int("perr_illegal_cmd", int'(protocol_err), 1);
        do_reset();

        // wdf_end without wdf_wren.
        app_wdf_end = 1'b1;
        idle(1);
        app_wdf_end = 1'b0;
        @(negedge aclk);
        check_int("perr_wdf_end", int'(protocol_err), 1);
        idle(1);
        do_reset();

        // Reset with three reads in flight.
        for (int i = 1; i < 4; i++) do_cmd(3'd1, AW'(i * 8), 1'b0, '0);
        v0 = vcount;
        do_reset();
        check_int("reset_flush", vcount - v0, 0);
        idle(RdL + 4);
        check_int("reset_flush_late", vcount - v0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
